// File: rtl/toggle_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package  : toggle_mem_pkg
// Brief    : Shared types and constants for the toggle-handshake memory
//            responder: FSM state encoding, captured command record and the
//            read-latency bound.
// Revision : 1.0 - initial release
// ============================================================================
package toggle_mem_pkg;

    // Upper bound on the memory read latency the wait counter can track.
    localparam int unsigned c_RD_LAT_MAX = 4;
    // Counter wide enough to hold c_RD_LAT_MAX.
    localparam int unsigned c_LAT_W      = 3;
    // Widest word address the command record can carry.
    localparam int unsigned c_AW_MAX     = 32;

    // Explicit state encodings.
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_WAIT   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = c_ST_IDLE,
        ACCESS = c_ST_ACCESS,
        WAIT   = c_ST_WAIT
    } state_t;

    // Command captured from the granted port when leaving IDLE.
    typedef struct packed {
        logic [c_AW_MAX-1:0] a;
        logic                we;
        logic [1:0]          ds;
        logic [15:0]         d;
        logic                grant;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/toggle_port_ctx.sv
`default_nettype none
// ============================================================================
// Module   : toggle_port_ctx
// Brief    : Per-port context of the toggle-handshake responder. Holds the
//            ack toggle flop and the read-data register, and reports whether
//            the requester has an outstanding request (req != ack).
// Ports    : clk, rst (async, active high)
//            i_req       requester toggle
//            i_complete  toggle ack this cycle
//            i_load_q    capture i_mem_q into the read-data register
//            i_mem_q     memory read data
//            o_ack       completion toggle
//            o_q         last read data of this port
//            o_pend      request outstanding
// Revision : 1.0 - initial release
// ============================================================================
module toggle_port_ctx (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_complete,
    input  logic        i_load_q,
    input  logic [15:0] i_mem_q,
    output logic        o_ack,
    output logic [15:0] o_q,
    output logic        o_pend
);

    logic        r_ack;
    logic [15:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack <= 1'b0;
            r_q   <= 16'h0000;
        end else begin
            if (i_complete) begin
                r_ack <= ~r_ack;
            end
            if (i_load_q) begin
                r_q <= i_mem_q;
            end
        end
    end

    assign o_ack  = r_ack;
    assign o_q    = r_q;
    // Uses the already-updated ack, so a request can be taken the cycle
    // right after the previous one completes.
    assign o_pend = i_req ^ r_ack;

endmodule
`default_nettype wire

// File: rtl/toggle_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : toggle_mem_responder
// Brief    : Two-port toggle-handshake memory responder. Arbitrates round-
//            robin between the ports and drives a synchronous 16-bit RAM
//            with fixed read latency RD_LAT (1..4).
// Ports    : clk_sys, reset (async, active high)
//            pN_req/pN_ack  toggle handshake of port N
//            pN_a/we/ds/d   command of port N, held stable while pending
//            pN_q           read data of port N
//            mem_cs/we/a/be/d, mem_q  synchronous RAM interface
//            busy           high whenever the FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module toggle_mem_responder #(
    parameter int unsigned AW     = 14,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          p0_req,
    output logic          p0_ack,
    input  logic [AW-1:0] p0_a,
    input  logic          p0_we,
    input  logic [1:0]    p0_ds,
    input  logic [15:0]   p0_d,
    output logic [15:0]   p0_q,
    input  logic          p1_req,
    output logic          p1_ack,
    input  logic [AW-1:0] p1_a,
    input  logic          p1_we,
    input  logic [1:0]    p1_ds,
    input  logic [15:0]   p1_d,
    output logic [15:0]   p1_q,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [1:0]    mem_be,
    output logic [15:0]   mem_d,
    input  logic [15:0]   mem_q,
    output logic          busy
);

    import toggle_mem_pkg::*;

    // Out-of-range latencies are clamped into the range the counter handles.
    localparam int unsigned c_LAT = (RD_LAT < 1) ? 1 :
                                    ((RD_LAT > c_RD_LAT_MAX) ? c_RD_LAT_MAX : RD_LAT);
    localparam logic [c_LAT_W-1:0] c_LAT_LOAD = c_LAT_W'(c_LAT);

    state_t               r_state;
    state_t               w_state_next;
    cmd_t                 r_cmd;
    cmd_t                 w_cmd;
    logic                 r_last_grant;
    logic [c_LAT_W-1:0]   r_lat_cnt;
    logic                 r_mem_cs;
    logic                 r_mem_we;
    logic [1:0]           r_mem_be;
    logic                 r_busy;

    logic [1:0]           w_req;
    logic [1:0]           w_ack;
    logic [1:0]           w_pend;
    logic [1:0]           w_complete;
    logic [1:0]           w_load_q;
    logic [15:0]          w_q [2];
    logic                 w_grant;
    logic                 w_take;
    logic                 w_done;
    logic                 w_done_rd;
    logic                 w_unused_cmd;

    assign w_req = {p1_req, p0_req};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            toggle_port_ctx u_ctx (
                .clk        (clk_sys),
                .rst        (reset),
                .i_req      (w_req[gi]),
                .i_complete (w_complete[gi]),
                .i_load_q   (w_load_q[gi]),
                .i_mem_q    (mem_q),
                .o_ack      (w_ack[gi]),
                .o_q        (w_q[gi]),
                .o_pend     (w_pend[gi])
            );
        end
    endgenerate

    // Round-robin: a tie goes to the port that was not served last.
    assign w_grant = (w_pend[0] & w_pend[1]) ? ~r_last_grant : w_pend[1];

    always_comb begin
        w_cmd = '0;
        if (w_grant) begin
            w_cmd.a[AW-1:0] = p1_a;
            w_cmd.we        = p1_we;
            w_cmd.ds        = p1_ds;
            w_cmd.d         = p1_d;
        end else begin
            w_cmd.a[AW-1:0] = p0_a;
            w_cmd.we        = p0_we;
            w_cmd.ds        = p0_ds;
            w_cmd.d         = p0_d;
        end
        w_cmd.grant = w_grant;
    end

    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_done       = 1'b0;
        w_done_rd    = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_pend) begin
                    w_take       = 1'b1;
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (r_cmd.we) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (r_lat_cnt == c_LAT_W'(1)) begin
                    w_done       = 1'b1;
                    w_done_rd    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Completion strobes steered to the port that owns the command.
    assign w_complete = w_done    ? (r_cmd.grant ? 2'b10 : 2'b01) : 2'b00;
    assign w_load_q   = w_done_rd ? (r_cmd.grant ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_cmd        <= '0;
            r_last_grant <= 1'b1;
            r_lat_cnt    <= '0;
            r_mem_cs     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= 2'b00;
            r_busy       <= 1'b0;
        end else begin
            // Strobes are set on the way into ACCESS so they are high for
            // exactly the ACCESS cycle and come straight from flops.
            r_busy   <= (w_state_next != IDLE);
            r_mem_cs <= w_take;
            r_mem_we <= w_take & w_cmd.we;
            r_mem_be <= (w_take & w_cmd.we) ? w_cmd.ds : 2'b00;
            if (w_take) begin
                r_cmd        <= w_cmd;
                r_last_grant <= w_grant;
            end
            if (r_state == ACCESS) begin
                r_lat_cnt <= c_LAT_LOAD;
            end else if (r_state == WAIT) begin
                r_lat_cnt <= r_lat_cnt - c_LAT_W'(1);
            end
        end
    end

    assign mem_cs = r_mem_cs;
    assign mem_we = r_mem_we;
    assign mem_be = r_mem_be;
    assign mem_a  = r_cmd.a[AW-1:0];
    assign mem_d  = r_cmd.d;
    assign busy   = r_busy;

    assign p0_ack = w_ack[0];
    assign p1_ack = w_ack[1];
    assign p0_q   = w_q[0];
    assign p1_q   = w_q[1];

    // Byte selects are consumed from w_cmd; the stored copy and the upper
    // address bits of the record are intentionally left unread.
    assign w_unused_cmd = ^{r_cmd.ds, r_cmd.a};

endmodule
`default_nettype wire

// File: tb/tb_toggle_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_toggle_mem_responder
// Brief    : Directed self-checking bench. Instance u_dut runs RD_LAT=1,
//            instance u_dut3 runs RD_LAT=3; each has its own RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_mem_responder;

    localparam int unsigned AW = 14;

    logic clk_sys;
    logic reset;

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // ---------------- RD_LAT = 1 instance ----------------
    logic          p0_req, p0_ack, p0_we;
    logic [AW-1:0] p0_a;
    logic [1:0]    p0_ds;
    logic [15:0]   p0_d, p0_q;
    logic          p1_req, p1_ack, p1_we;
    logic [AW-1:0] p1_a;
    logic [1:0]    p1_ds;
    logic [15:0]   p1_d, p1_q;
    logic          mem_cs, mem_we, busy;
    logic [AW-1:0] mem_a;
    logic [1:0]    mem_be;
    logic [15:0]   mem_d, mem_q;

    toggle_mem_responder #(.AW(AW), .RD_LAT(1)) u_dut (
        .clk_sys(clk_sys), .reset(reset),
        .p0_req(p0_req), .p0_ack(p0_ack), .p0_a(p0_a), .p0_we(p0_we),
        .p0_ds(p0_ds), .p0_d(p0_d), .p0_q(p0_q),
        .p1_req(p1_req), .p1_ack(p1_ack), .p1_a(p1_a), .p1_we(p1_we),
        .p1_ds(p1_ds), .p1_d(p1_d), .p1_q(p1_q),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_a(mem_a), .mem_be(mem_be),
        .mem_d(mem_d), .mem_q(mem_q), .busy(busy)
    );

    logic [15:0] ram_a [0:(1<<AW)-1];
    logic [15:0] rd_a;
    always @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < (1<<AW); i++) ram_a[i] <= 16'(i) + 16'h1000;
        end else if (mem_cs) begin
            if (mem_be[0]) ram_a[mem_a][7:0]  <= mem_d[7:0];
            if (mem_be[1]) ram_a[mem_a][15:8] <= mem_d[15:8];
            rd_a <= ram_a[mem_a];
        end
    end
    assign mem_q = rd_a;

    // ---------------- RD_LAT = 3 instance ----------------
    logic          b_p0_req, b_p0_ack, b_p0_we;
    logic [AW-1:0] b_p0_a;
    logic [1:0]    b_p0_ds;
    logic [15:0]   b_p0_d, b_p0_q;
    logic          b_p1_req, b_p1_ack, b_p1_we;
    logic [AW-1:0] b_p1_a;
    logic [1:0]    b_p1_ds;
    logic [15:0]   b_p1_d, b_p1_q;
    logic          b_mem_cs, b_mem_we, b_busy;
    logic [AW-1:0] b_mem_a;
    logic [1:0]    b_mem_be;
    logic [15:0]   b_mem_d, b_mem_q;

    toggle_mem_responder #(.AW(AW), .RD_LAT(3)) u_dut3 (
        .clk_sys(clk_sys), .reset(reset),
        .p0_req(b_p0_req), .p0_ack(b_p0_ack), .p0_a(b_p0_a), .p0_we(b_p0_we),
        .p0_ds(b_p0_ds), .p0_d(b_p0_d), .p0_q(b_p0_q),
        .p1_req(b_p1_req), .p1_ack(b_p1_ack), .p1_a(b_p1_a), .p1_we(b_p1_we),
        .p1_ds(b_p1_ds), .p1_d(b_p1_d), .p1_q(b_p1_q),
        .mem_cs(b_mem_cs), .mem_we(b_mem_we), .mem_a(b_mem_a), .mem_be(b_mem_be),
        .mem_d(b_mem_d), .mem_q(b_mem_q), .busy(b_busy)
    );

    logic [15:0] ram_b [0:(1<<AW)-1];
    logic [15:0] pb0, pb1, pb2;
    always @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < (1<<AW); i++) ram_b[i] <= 16'(i) + 16'h2000;
        end else if (b_mem_cs) begin
            if (b_mem_be[0]) ram_b[b_mem_a][7:0]  <= b_mem_d[7:0];
            if (b_mem_be[1]) ram_b[b_mem_a][15:8] <= b_mem_d[15:8];
            pb0 <= ram_b[b_mem_a];
        end
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign b_mem_q = pb2;

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (p0_ack !== 1'b0 || p1_ack !== 1'b0) begin errors++;
            $display("FAIL reset_ack: got %b %b, want 0 0", p0_ack, p1_ack); end
        checks++; if (p0_q !== 16'h0000 || p1_q !== 16'h0000) begin errors++;
            $display("FAIL reset_q: got %h %h, want 0000 0000", p0_q, p1_q); end
        checks++; if (mem_cs !== 1'b0 || mem_we !== 1'b0 || mem_be !== 2'b00) begin errors++;
            $display("FAIL reset_strobes: got cs=%b we=%b be=%b, want 0 0 00", mem_cs, mem_we, mem_be); end
        checks++; if (mem_a !== '0 || mem_d !== 16'h0000) begin errors++;
            $display("FAIL reset_addr_data: got a=%h d=%h, want 0 0", mem_a, mem_d); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b, want 0", busy); end
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || mem_cs !== 1'b0) begin errors++;
            $display("FAIL idle_after_reset: got busy=%b cs=%b, want 0 0", busy, mem_cs); end
    endtask

    task automatic test_tie();
        p0_a = 14'h0005; p0_we = 1'b0; p1_a = 14'h0006; p1_we = 1'b0;
        p0_req = ~p0_req; p1_req = ~p1_req;                  // cycle T
        tick();                                              // T+1
        checks++; if (mem_cs !== 1'b1 || mem_a !== 14'h0005) begin errors++;
            $display("FAIL tie_first_grant: got cs=%b a=%h, want 1 0005", mem_cs, mem_a); end
        tick(); tick();                                      // T+3
        checks++; if (p0_ack !== p0_req || p0_q !== 16'h1005) begin errors++;
            $display("FAIL tie_p0_done: got ack=%b q=%h, want %b 1005", p0_ack, p0_q, p0_req); end
        checks++; if (p1_ack === p1_req) begin errors++;
            $display("FAIL tie_p1_waiting: got ack=%b, want %b", p1_ack, ~p1_req); end
        // Port 0 re-requests at once: a second tie, now won by port 1.
        p0_a = 14'h0007; p0_req = ~p0_req;
        tick();                                              // T+4
        checks++; if (mem_cs !== 1'b1 || mem_a !== 14'h0006) begin errors++;
            $display("FAIL tie_second_grant: got cs=%b a=%h, want 1 0006", mem_cs, mem_a); end
        tick(); tick();                                      // T+6
        checks++; if (p1_ack !== p1_req || p1_q !== 16'h1006) begin errors++;
            $display("FAIL tie_p1_done: got ack=%b q=%h, want %b 1006", p1_ack, p1_q, p1_req); end
        tick();                                              // T+7
        checks++; if (mem_cs !== 1'b1 || mem_a !== 14'h0007) begin errors++;
            $display("FAIL tie_p0_retry: got cs=%b a=%h, want 1 0007", mem_cs, mem_a); end
        tick(); tick();                                      // T+9
        checks++; if (p0_ack !== p0_req || p0_q !== 16'h1007) begin errors++;
            $display("FAIL tie_p0_retry_done: got ack=%b q=%h, want %b 1007", p0_ack, p0_q, p0_req); end
    endtask

    task automatic test_write_read();
        logic ack0;
        ack0 = p0_ack;
        p0_a = 14'h0010; p0_we = 1'b1; p0_ds = 2'b11; p0_d = 16'hA55A;
        p0_req = ~p0_req;
        tick();
        checks++; if (mem_cs !== 1'b1 || mem_we !== 1'b1 || mem_a !== 14'h0010 ||
                      mem_be !== 2'b11 || mem_d !== 16'hA55A) begin errors++;
            $display("FAIL wr_access: got cs=%b we=%b a=%h be=%b d=%h, want 1 1 0010 11 a55a",
                     mem_cs, mem_we, mem_a, mem_be, mem_d); end
        checks++; if (p0_ack !== ack0 || busy !== 1'b1) begin errors++;
            $display("FAIL wr_early: got ack=%b busy=%b, want %b 1", p0_ack, busy, ack0); end
        tick();
        checks++; if (p0_ack !== ~ack0 || busy !== 1'b0) begin errors++;
            $display("FAIL wr_ack: got ack=%b busy=%b, want %b 0", p0_ack, busy, ~ack0); end
        checks++; if (p0_q !== 16'h1007) begin errors++;
            $display("FAIL wr_q_hold: got %h, want 1007", p0_q); end
        p0_we = 1'b0;
        p0_req = ~p0_req;
        tick();
        checks++; if (mem_cs !== 1'b1 || mem_we !== 1'b0 || mem_be !== 2'b00) begin errors++;
            $display("FAIL rd_access: got cs=%b we=%b be=%b, want 1 0 00", mem_cs, mem_we, mem_be); end
        tick();
        checks++; if (p0_ack !== ~ack0 || busy !== 1'b1) begin errors++;
            $display("FAIL rd_early: got ack=%b busy=%b, want %b 1", p0_ack, busy, ~ack0); end
        tick();
        checks++; if (p0_ack !== ack0 || p0_q !== 16'hA55A) begin errors++;
            $display("FAIL rd_done: got ack=%b q=%h, want %b a55a", p0_ack, p0_q, ack0); end
        checks++; if (p1_q !== 16'h1006) begin errors++;
            $display("FAIL other_q_hold: got %h, want 1006", p1_q); end
    endtask

    task automatic test_byte_select();
        p0_a = 14'h0020; p0_we = 1'b1; p0_ds = 2'b11; p0_d = 16'h1234;
        p0_req = ~p0_req;
        tick(); tick();
        p0_ds = 2'b10; p0_d = 16'hFF00;
        p0_req = ~p0_req;
        tick();
        checks++; if (mem_be !== 2'b10 || mem_d !== 16'hFF00) begin errors++;
            $display("FAIL bs_be: got be=%b d=%h, want 10 ff00", mem_be, mem_d); end
        tick();
        checks++; if (p0_ack !== p0_req || p0_q !== 16'hA55A) begin errors++;
            $display("FAIL bs_wr_done: got ack=%b q=%h, want %b a55a", p0_ack, p0_q, p0_req); end
        p0_we = 1'b0;
        p0_req = ~p0_req;
        repeat (3) tick();
        checks++; if (p0_ack !== p0_req || p0_q !== 16'hFF34) begin errors++;
            $display("FAIL bs_readback: got ack=%b q=%h, want %b ff34", p0_ack, p0_q, p0_req); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            b_p1_a = 14'(32'h40 + k); b_p1_we = 1'b0;
            b_p1_req = ~b_p1_req;
            repeat (4) tick();
            checks++; if (b_p1_ack === b_p1_req) begin errors++;
                $display("FAIL b2b_early[%0d]: got ack=%b, want %b", k, b_p1_ack, ~b_p1_req); end
            tick();
            checks++; if (b_p1_ack !== b_p1_req || b_p1_q !== 16'(32'h2040 + k)) begin errors++;
                $display("FAIL b2b_done[%0d]: got ack=%b q=%h, want %b %h",
                         k, b_p1_ack, b_p1_q, b_p1_req, 16'(32'h2040 + k)); end
            checks++; if (b_p0_ack !== 1'b0 || b_p0_q !== 16'h0000) begin errors++;
                $display("FAIL b2b_p0_quiet[%0d]: got ack=%b q=%h, want 0 0000", k, b_p0_ack, b_p0_q); end
        end
    endtask

    task automatic test_interleave();
        int   wr_sent, rd_sent, wr_ack, rd_ack, cyc;
        logic prev0, prev1, last_we, have_last;
        wr_sent = 0; rd_sent = 0; wr_ack = 0; rd_ack = 0; cyc = 0;
        prev0 = p0_ack; prev1 = p1_ack; last_we = 1'b0; have_last = 1'b0;
        p0_we = 1'b1; p0_ds = 2'b11; p1_we = 1'b0;
        while ((wr_ack < 6 || rd_ack < 6) && cyc < 200) begin
            if (p0_ack === p0_req && wr_sent < 6) begin
                p0_a = 14'(32'h200 + wr_sent); p0_d = 16'(32'hB000 + wr_sent);
                p0_req = ~p0_req; wr_sent++;
            end
            if (p1_ack === p1_req && rd_sent < 6) begin
                p1_a = 14'(32'h100 + rd_sent);
                p1_req = ~p1_req; rd_sent++;
            end
            tick(); cyc++;
            if (mem_cs === 1'b1) begin
                if (have_last) begin
                    checks++; if (mem_we === last_we) begin errors++;
                        $display("FAIL il_alternate: got we=%b twice in a row, want %b", mem_we, ~last_we); end
                end
                last_we = mem_we; have_last = 1'b1;
            end
            if (p0_ack !== prev0) begin wr_ack++; prev0 = p0_ack; end
            if (p1_ack !== prev1) begin
                checks++; if (p1_q !== 16'(32'h1100 + rd_ack)) begin errors++;
                    $display("FAIL il_rd_data[%0d]: got %h, want %h", rd_ack, p1_q, 16'(32'h1100 + rd_ack)); end
                rd_ack++; prev1 = p1_ack;
            end
        end
        repeat (5) tick();
        checks++; if (wr_ack != 6 || rd_ack != 6 || p0_ack !== prev0 || p1_ack !== prev1) begin errors++;
            $display("FAIL il_ack_count: got wr=%0d rd=%0d (extra=%b%b), want 6 6 (00)",
                     wr_ack, rd_ack, p0_ack ^ prev0, p1_ack ^ prev1); end
        p0_a = 14'h0203; p0_we = 1'b0;
        p0_req = ~p0_req;
        repeat (3) tick();
        checks++; if (p0_ack !== p0_req || p0_q !== 16'hB003) begin errors++;
            $display("FAIL il_write_data: got ack=%b q=%h, want %b b003", p0_ack, p0_q, p0_req); end
    endtask

    task automatic test_reset_wait();
        if (p0_req === 1'b1) begin
            p0_we = 1'b0; p0_a = '0; p0_req = 1'b0;
            repeat (3) tick();
        end
        p0_we = 1'b0; p0_a = 14'h0009; p0_req = 1'b1;       // cycle T
        tick(); tick();                                      // T+2, WAIT
        checks++; if (busy !== 1'b1) begin errors++;
            $display("FAIL rw_busy_before: got %b, want 1", busy); end
        reset = 1'b1; p1_req = 1'b0;
        #1;
        checks++; if (p0_ack !== 1'b0 || p0_q !== 16'h0000 || busy !== 1'b0 || mem_cs !== 1'b0) begin errors++;
            $display("FAIL rw_async_clear: got ack=%b q=%h busy=%b cs=%b, want 0 0000 0 0",
                     p0_ack, p0_q, busy, mem_cs); end
        tick();
        checks++; if (mem_cs !== 1'b0 || p0_ack !== 1'b0) begin errors++;
            $display("FAIL rw_held: got cs=%b ack=%b, want 0 0", mem_cs, p0_ack); end
        tick();
        reset = 1'b0;                                        // cycle R
        tick();
        checks++; if (mem_cs !== 1'b1 || mem_a !== 14'h0009) begin errors++;
            $display("FAIL rw_reissue: got cs=%b a=%h, want 1 0009", mem_cs, mem_a); end
        tick(); tick();
        checks++; if (p0_ack !== 1'b1 || p0_q !== 16'h1009 || p1_ack !== 1'b0) begin errors++;
            $display("FAIL rw_done: got ack=%b q=%h p1_ack=%b, want 1 1009 0", p0_ack, p0_q, p1_ack); end
    endtask

    initial begin
        reset = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_a = '0; p0_ds = 2'b00; p0_d = 16'h0000;
        p1_req = 1'b0; p1_we = 1'b0; p1_a = '0; p1_ds = 2'b00; p1_d = 16'h0000;
        b_p0_req = 1'b0; b_p0_we = 1'b0; b_p0_a = '0; b_p0_ds = 2'b00; b_p0_d = 16'h0000;
        b_p1_req = 1'b0; b_p1_we = 1'b0; b_p1_a = '0; b_p1_ds = 2'b00; b_p1_d = 16'h0000;
        tick();
        test_reset();
        test_tie();
        test_write_read();
        test_byte_select();
        test_back_to_back();
        test_interleave();
        test_reset_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
